// File: rtl/array_west_feeder_pkg.sv
// Shared instruction codes, FSM states and helpers for the west-edge feeder.
// Used by array_west_feeder and array_west_feeder_skew_line.
package array_west_feeder_pkg;

  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GAP,
    S_EXEC,
    S_DRAIN
  } feeder_state_e;

  function automatic int drain_cycles(int rows, int cols, bit skew);
    return skew ? rows + cols : cols;
  endfunction

endpackage

// File: rtl/array_west_feeder_if.sv
// L0 vector stream into the west feeder: valid/ready handshake.
// master = L0 buffer side, slave = feeder side.
interface array_west_feeder_if #(
  parameter int row = 8,
  parameter int bw  = 4
);

  logic [row*bw-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/array_west_feeder_skew_line.sv
// Per-row delay line: depth registers, synchronous active-high clear.
// Builds the diagonal wavefront on the west edge of the array.
module array_west_feeder_skew_line #(
  parameter int depth = 1,
  parameter int width = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] d_i,
  output logic [width-1:0] q_o
);

  logic [width-1:0] pipe_q [depth];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < depth; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < depth; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign q_o = pipe_q[depth-1];

endmodule

// File: rtl/array_west_feeder.sv
// West-edge feeder: kernel load then execute, skewed per row.
// FEEDER_SKEW_EN: row r delayed r cycles; otherwise all rows share row 0.
module array_west_feeder
  import array_west_feeder_pkg::*;
#(
  parameter int bw     = 4,
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int len_bw = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [len_bw-1:0]     num_vec,
  array_west_feeder_if.slave    l0,
  output logic [row*bw-1:0]     out_w,
  output logic [2*row-1:0]      inst_w,
  output logic                  busy,
  output logic                  done
);

`ifdef FEEDER_SKEW_EN
  localparam bit SKEW = 1'b1;
`else
  localparam bit SKEW = 1'b0;
`endif

  localparam int DRAIN_LEN = drain_cycles(row, col, SKEW);
  localparam int DW = $clog2(DRAIN_LEN + 1);
  localparam logic [len_bw-1:0] COL_LAST = len_bw'(col - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_LEN - 1);

  feeder_state_e     state_q, state_d;
  logic [len_bw-1:0] cnt_q, cnt_d;
  logic [len_bw-1:0] num_q, num_d;
  logic [DW-1:0]     dcnt_q, dcnt_d;
  logic [row*bw-1:0] data0_q, data0_d;
  logic [1:0]        inst0_q, inst0_d;
  logic              rdy_q;
  logic              busy_q;
  logic              done_q, done_d;
  logic              xfer;

  assign xfer = l0.in_valid & rdy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    dcnt_d  = dcnt_q;
    data0_d = data0_q;
    inst0_d = INST_IDLE;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d   = num_vec;
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          inst0_d = INST_LOAD;
          data0_d = l0.in_data;
          if (cnt_q == COL_LAST) begin
            cnt_d   = '0;
            state_d = S_GAP;
          end else begin
            cnt_d = cnt_q + len_bw'(1);
          end
        end
      end
      S_GAP: begin
        dcnt_d  = '0;
        state_d = (num_q == '0) ? S_DRAIN : S_EXEC;
      end
      S_EXEC: begin
        if (xfer) begin
          inst0_d = INST_EXEC;
          data0_d = l0.in_data;
          // compare against num-1 so the all-ones count never wraps
          if (cnt_q == num_q - len_bw'(1)) begin
            dcnt_d  = '0;
            state_d = S_DRAIN;
          end else begin
            cnt_d = cnt_q + len_bw'(1);
          end
        end
      end
      S_DRAIN: begin
        if (dcnt_q == DRAIN_LAST) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      num_q   <= '0;
      dcnt_q  <= '0;
      data0_q <= '0;
      inst0_q <= INST_IDLE;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      dcnt_q  <= dcnt_d;
      data0_q <= data0_d;
      inst0_q <= inst0_d;
      rdy_q   <= (state_d == S_LOAD) || (state_d == S_EXEC);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= done_d;
    end
  end

  assign l0.in_ready = rdy_q;
  assign busy        = busy_q;
  assign done        = done_q;

`ifdef FEEDER_SKEW_EN
  for (genvar r = 0; r < row; r++) begin : g_row
    if (r == 0) begin : g_head
      assign out_w[0 +: bw] = data0_q[0 +: bw];
      assign inst_w[0 +: 2] = inst0_q;
    end else begin : g_skew
      logic [bw+1:0] lane;
      array_west_feeder_skew_line #(
        .depth(r),
        .width(bw + 2)
      ) u_skew (
        .clk  (clk),
        .reset(reset),
        .d_i  ({inst0_q, data0_q[r*bw +: bw]}),
        .q_o  (lane)
      );
      assign out_w[r*bw +: bw] = lane[bw-1:0];
      assign inst_w[2*r +: 2]  = lane[bw +: 2];
    end
  end
`else
  assign out_w  = data0_q;
  assign inst_w = {row{inst0_q}};
`endif

endmodule

// File: tb/tb_array_west_feeder.sv
// Directed bench for array_west_feeder; adapts to FEEDER_SKEW_EN.
// Samples 1 time unit after each rising edge.
module tb_array_west_feeder;

  localparam int BW  = 4;
  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int LB  = 8;
`ifdef FEEDER_SKEW_EN
  localparam int SKEW = 1;
`else
  localparam int SKEW = 0;
`endif
  localparam int D = SKEW ? ROW + COL : COL;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [LB-1:0]     num_vec = '0;
  logic [ROW*BW-1:0] out_w;
  logic [2*ROW-1:0]  inst_w;
  logic              busy;
  logic              done;

  array_west_feeder_if #(.row(ROW), .bw(BW)) l0 ();

  array_west_feeder #(
    .bw(BW), .row(ROW), .col(COL), .len_bw(LB)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .num_vec(num_vec),
    .l0     (l0),
    .out_w  (out_w),
    .inst_w (inst_w),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int e = 0;
  int nx = 0;
  int xe [0:511];
  logic [2*ROW-1:0]  ins_h [0:2047];
  logic [ROW*BW-1:0] dat_h [0:2047];
  logic              don_h [0:2047];
  logic              bsy_h [0:2047];

  function automatic logic [BW-1:0] nib(int k, int r);
    return BW'((k * 7 + r * 3 + 1) % 16);
  endfunction

  function automatic logic [ROW*BW-1:0] vec(int k);
    logic [ROW*BW-1:0] v;
    v = '0;
    for (int r = 0; r < ROW; r++) v[r*BW +: BW] = nib(k, r);
    return v;
  endfunction

  function automatic logic [63:0] seq(int r, int a, int n);
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < n; i++) s = {s[61:0], ins_h[a+i][2*r +: 2]};
    return s;
  endfunction

  function automatic int cnt_exec(int r, int a, int b);
    int c;
    c = 0;
    for (int i = a; i <= b; i++) if (ins_h[i][2*r +: 2] == 2'b10) c++;
    return c;
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    logic x;
    x = l0.in_valid && l0.in_ready;
    @(posedge clk);
    #1;
    if (e < 2047) e++;
    if (x && nx < 511) begin
      xe[nx] = e;
      nx++;
    end
    ins_h[e] = inst_w;
    dat_h[e] = out_w;
    don_h[e] = done;
    bsy_h[e] = busy;
    l0.in_data = vec(nx);
  endtask

  task automatic run_job(input int nv, input int stall_len,
                         input int rst_k, input int xs_k,
                         output int s, output int d);
    int  stalled;
    bit  xs_done;
    bit  rst_now;
    stalled = 0;
    xs_done = 1'b0;
    nx = 0;
    l0.in_data  = vec(0);
    l0.in_valid = 1'b1;
    num_vec = LB'(nv);
    start = 1'b1;
    step();
    start = 1'b0;
    s = e;
    d = -1;
    for (int i = 0; i < 400; i++) begin
      l0.in_valid = 1'b1;
      if (stall_len > 0 && nx == COL + 2 && stalled < stall_len) begin
        l0.in_valid = 1'b0;
        stalled++;
      end
      if (nx == xs_k && !xs_done) begin
        start   = 1'b1;
        num_vec = LB'(5);
        xs_done = 1'b1;
      end
      rst_now = (nx == rst_k);
      reset = rst_now;
      step();
      start = 1'b0;
      reset = 1'b0;
      if (rst_now || don_h[e]) begin
        d = e;
        break;
      end
    end
  endtask

  task automatic check_data(string tag);
    int ed;
    for (int k = 0; k < nx; k++) begin
      for (int r = 0; r < ROW; r++) begin
        ed = xe[k] + SKEW * r;
        chk({tag, "_dat"}, 64'(dat_h[ed][r*BW +: BW]), 64'(nib(k, r)));
        chk({tag, "_ins"}, 64'(ins_h[ed][2*r +: 2]),
            (k < COL) ? 64'd1 : 64'd2);
      end
    end
  endtask

  int s, d, nd;

  initial begin
    // reset held with valid and start high
    reset = 1'b1;
    start = 1'b1;
    num_vec = LB'(4);
    l0.in_valid = 1'b1;
    l0.in_data = vec(0);
    repeat (3) step();
    chk("rst_ready", 64'(l0.in_ready), 64'd0);
    chk("rst_inst", 64'(inst_w), 64'd0);
    chk("rst_out", 64'(out_w), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    reset = 1'b0;
    start = 1'b0;
    step();
    chk("rst_start_ignored", 64'(busy), 64'd0);

    run_job(4, 0, -1, -1, s, d);
    chk("t2_xfers", 64'(nx), 64'd12);
    chk("t2_lat", 64'(d - s), 64'(13 + D));
    chk("t2_row0", seq(0, s + 1, 14), 64'({16'h5555, 2'b00, 8'hAA, 2'b00}));
    chk("t2_rowN", seq(ROW - 1, s + 1 + SKEW * (ROW - 1), 14),
        64'({16'h5555, 2'b00, 8'hAA, 2'b00}));
    check_data("t2");
    chk("t2_busy", 64'(bsy_h[s]), 64'd1);
    chk("t2_idle", 64'(bsy_h[d]), 64'd0);
    step();
    chk("t2_pulse", 64'(don_h[e]), 64'd0);

    run_job(4, 3, -1, -1, s, d);
    chk("t3_xfers", 64'(nx), 64'd12);
    chk("t3_lat", 64'(d - s), 64'(16 + D));
    chk("t3_row0", seq(0, s + 1, 17),
        64'({16'h5555, 2'b00, 4'hA, 6'b000000, 4'hA, 2'b00}));
    check_data("t3");

    run_job(0, 0, -1, 3, s, d);
    chk("t4_xfers", 64'(nx), 64'd8);
    chk("t4_lat", 64'(d - s), 64'(9 + D));
    chk("t4_row0", seq(0, s + 1, 10), 64'({16'h5555, 4'h0}));
    nd = 0;
    for (int r = 0; r < ROW; r++) nd += cnt_exec(r, s, d);
    chk("t4_noexec", 64'(nd), 64'd0);
    check_data("t4");

    run_job(4, 0, COL + 1, -1, s, d);
    chk("t5_busy", 64'(bsy_h[d]), 64'd0);
    chk("t5_ready", 64'(l0.in_ready), 64'd0);
    chk("t5_inst", 64'(ins_h[d]), 64'd0);
    chk("t5_out", 64'(dat_h[d]), 64'd0);
    chk("t5_done", 64'(don_h[d]), 64'd0);
    nd = 0;
    l0.in_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (done || inst_w != '0) nd++;
    end
    chk("t5_quiet", 64'(nd), 64'd0);
    run_job(4, 0, -1, -1, s, d);
    chk("t5_xfers", 64'(nx), 64'd12);
    chk("t5_lat", 64'(d - s), 64'(13 + D));

    run_job(255, 0, -1, -1, s, d);
    chk("t7_xfers", 64'(nx), 64'd263);
    chk("t7_lat", 64'(d - s), 64'(264 + D));
    chk("t7_exec", 64'(cnt_exec(0, s, d)), 64'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
